// File: rtl/regfile_sb.sv
// Integer register file: two write-back ports, optional write-to-read bypass,
// and a per-register pending-write scoreboard for long-latency destinations.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_ready,
  output logic            rs2_ready,
  input  logic            we_a,
  input  logic [AW-1:0]   waddr_a,
  input  logic [XLEN-1:0] wdata_a,
  input  logic            we_b,
  input  logic [AW-1:0]   waddr_b,
  input  logic [XLEN-1:0] wdata_b,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            pending_any
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  logic wr_a, wr_b, iss;

  assign wr_a = we_a && (waddr_a != '0);
  assign wr_b = we_b && (waddr_b != '0);
  assign iss  = issue_valid && (issue_rd != '0);

  // Port B is applied after port A so it wins on a shared address; the
  // scoreboard set is applied after the clear so a same-cycle issue wins.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_a) regs_d[waddr_a] = wdata_a;
    if (wr_b) begin
      regs_d[waddr_b] = wdata_b;
      pend_d[waddr_b] = 1'b0;
    end
    if (iss) pend_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  logic [1:0][AW-1:0]   rd_addr;
  logic [1:0][XLEN-1:0] rd_data;
  logic [1:0]           rd_rdy;

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic zero_or_rst, hit_a, hit_b;

    assign zero_or_rst = reset || (rd_addr[p] == '0);
    assign hit_a       = BYPASS && we_a && (waddr_a == rd_addr[p]);
    assign hit_b       = BYPASS && we_b && (waddr_b == rd_addr[p]);

    assign rd_data[p] = zero_or_rst ? '0      :
                        hit_b       ? wdata_b :
                        hit_a       ? wdata_a :
                                      regs_q[rd_addr[p]];

    assign rd_rdy[p]  = zero_or_rst || !pend_q[rd_addr[p]] || hit_b;
  end

  assign rs1_data    = rd_data[0];
  assign rs2_data    = rd_data[1];
  assign rs1_ready   = rd_rdy[0];
  assign rs2_ready   = rd_rdy[1];
  assign pending_any = !reset && (|pend_q);

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with two write-back ports, write-to-read bypass and a per-register pending-write scoreboard. It sits in the decode/write-back stage of the RISC-V core. Decode reads operands and checks hazards here, the ALU write-back and load/UART write-back retire results here, and issue marks destinations busy. It succeeds the fixed 32×32, single-write register file: width and depth are generalised, registers reset to zero, and load-use hazard tracking is added.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥2)
- AW, $clog2(NREG), register address width (derived, not overridden)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all registers and scoreboard
- rs1_addr, rs2_addr  in  AW  read addresses
- rs1_data, rs2_data  out  XLEN  read data (combinational)
- rs1_ready, rs2_ready  out  1  operand not awaiting a pending write
- we_a  in  1  ALU write-back enable
- waddr_a  in  AW  ALU write-back address
- wdata_a  in  XLEN  ALU write-back data
- we_b  in  1  load/peripheral write-back enable; also clears pending bit
- waddr_b  in  AW  load write-back address
- wdata_b  in  XLEN  load write-back data
- issue_valid  in  1  a long-latency instruction issues this cycle
- issue_rd  in  AW  its destination register
- pending_any  out  1  OR of all pending bits

## Operation
- Storage: NREG×XLEN registers and NREG pending bits; register 0 has neither (reads 0, always ready).
- Writes: at clk edge, port A writes waddr_a if we_a and waddr_a≠0; port B likewise. Same nonzero address on both ports: port B wins (load retires later in program order).
- Scoreboard set: issue_valid and issue_rd≠0 sets pending[issue_rd].
- Scoreboard clear: we_b and waddr_b≠0 clears pending[waddr_b]. Port A never touches pending.
- Set and clear of the same register in one cycle: set wins, pending stays 1.
- Read: rsN_addr=0 → 0. Otherwise, with BYPASS=1, matching we_b → wdata_b; else matching we_a → wdata_a; else stored value. With BYPASS=0, stored value only.
- Ready: rsN_ready = 1 if rsN_addr=0 or pending[rsN_addr]=0. With BYPASS=1, also 1 when we_b targets rsN_addr this cycle.
- issue_valid to a register already pending: bit stays set; no counting, one we_b clears it.
- pending_any reflects registered pending bits only, with no bypass.

## Timing
- Read path and ready are combinational from addresses, write ports and state; zero latency.
- Write visible from the stored array the cycle after the edge; with BYPASS=1, visible in the same cycle.
- Pending set at edge N is visible as rsN_ready=0 in cycle N+1.
- Reset (sampled at edge): all registers ← 0, all pending ← 0, pending_any ← 0. Writes and issues in the reset cycle are discarded.
- While reset=1: rs1_data=rs2_data=0, rs1_ready=rs2_ready=1, pending_any=0, regardless of bypass.
- Reset asserted mid-operation (pending bits set, writes in flight) fully clears state; nothing survives.
- No X propagation: all state is defined after the first reset edge.

## Test plan
- Reset, then read all addresses → every rs data 0, ready=1, pending_any=0. Write 0xDEADBEEF to x0 via both ports → x0 still reads 0.
- we_a x5=0x00000006, next cycle read rs1=x5 → 0x00000006. Same-cycle read with BYPASS=1 → 0x00000006; with BYPASS=0 → old value 0.
- we_a and we_b both to x7, A=0x101, B=0x202 → x7=0x202 next cycle; same-cycle bypass also gives 0x202.
- issue_valid rd=x9 → next cycle rs2=x9 ready=0, pending_any=1. we_b x9=0x80000000 → same cycle ready=1 with data 0x80000000 (BYPASS=1), next cycle pending_any=0.
- issue_valid rd=x12 together with we_b x12=0x1 → x12=0x1 stored, pending[12] remains 1, rs1_ready=0 next cycle.
- Set pending on x3, x4 and write x10=0x30, then assert reset one cycle → x10 reads 0, x3/x4 ready=1, pending_any=0.
